// File: rtl/timer_device.sv
// Memory-mapped interval timer: prescaled counter, programmable limit, sticky ready/overrun flags.
// Define TIMER_IRQ_EN to build the writable interrupt-enable bit and the irq output.
module timer_device #(
    parameter int          DBITS     = 32,
    parameter logic [31:0] ADDR_TCNT = 32'hF0000020,
    parameter logic [31:0] ADDR_TLIM = 32'hF0000024,
    parameter logic [31:0] ADDR_TCTL = 32'hF0000120,
    parameter logic [31:0] DIVIDER   = 32'd50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DBITS-1:0] ABUS,
    inout  logic [DBITS-1:0] DBUS,
    input  logic             we,
    output logic             irq
);

    localparam logic [31:0] PRESC_LAST = DIVIDER - 32'd1;

    logic [31:0]      presc;
    logic [DBITS-1:0] tcnt;
    logic [DBITS-1:0] tlim;
    logic [DBITS-1:0] tlimLast;
    logic             ready;
    logic             overrun;
    logic             ie;
    logic             tick;
    logic             limHit;
    logic             selTcnt;
    logic             selTlim;
    logic             selTctl;
    logic             tcntWr;
    logic             tlimWr;
    logic             tctlWr;
    logic             rdEn;
    logic [DBITS-1:0] rdData;

    assign selTcnt = (ABUS == ADDR_TCNT);
    assign selTlim = (ABUS == ADDR_TLIM);
    assign selTctl = (ABUS == ADDR_TCTL);

    assign tcntWr = we & selTcnt;
    assign tlimWr = we & selTlim;
    assign tctlWr = we & selTctl;

    assign tick     = (presc == PRESC_LAST);
    assign tlimLast = tlim - DBITS'(1);
    // A counter load in the same cycle overrides the tick, so it also suppresses a limit hit.
    assign limHit   = tick & ~tcntWr & (tlim != '0) & (tcnt == tlimLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tcntWr || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (tcntWr) begin
            tcnt <= DBUS;
        end else if (limHit) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= tcnt + DBITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlim <= '0;
        end else if (tlimWr) begin
            tlim <= DBUS;
        end
    end

    // Hardware set of a flag takes priority over a software clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (limHit) begin
                ready <= 1'b1;
            end else if (tctlWr && !DBUS[0]) begin
                ready <= 1'b0;
            end
            if (limHit && ready) begin
                overrun <= 1'b1;
            end else if (tctlWr && !DBUS[2]) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef TIMER_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie <= 1'b0;
        end else if (tctlWr) begin
            ie <= DBUS[4];
        end
    end

    assign irq = ready & ie;
`else
    assign ie  = 1'b0;
    assign irq = 1'b0;
`endif

    always_comb begin
        rdData = '0;
        if (selTcnt) begin
            rdData = tcnt;
        end else if (selTlim) begin
            rdData = tlim;
        end else if (selTctl) begin
            rdData[0] = ready;
            rdData[2] = overrun;
            rdData[4] = ie;
        end
    end

    assign rdEn = ~rst & ~we & (selTcnt | selTlim | selTctl);
    assign DBUS = rdEn ? rdData : 'z;

endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device with DIVIDER=4; irq expectations follow TIMER_IRQ_EN.
module tb_timer_device;

    localparam logic [31:0] A_TCNT = 32'hF0000020;
    localparam logic [31:0] A_TLIM = 32'hF0000024;
    localparam logic [31:0] A_TCTL = 32'hF0000120;

`ifdef TIMER_IRQ_EN
    localparam logic        IRQ_ON  = 1'b1;
    localparam logic [31:0] IE_BIT  = 32'h10;
`else
    localparam logic        IRQ_ON  = 1'b0;
    localparam logic [31:0] IE_BIT  = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] abus;
    logic        we;
    logic        irq;
    logic        tbDrv;
    logic [31:0] tbData;
    wire  [31:0] dbus;

    int checks   = 0;
    int failures = 0;

    assign dbus = tbDrv ? tbData : 'z;

    timer_device #(
        .DBITS    (32),
        .ADDR_TCNT(A_TCNT),
        .ADDR_TLIM(A_TLIM),
        .ADDR_TCTL(A_TCTL),
        .DIVIDER  (32'd4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ABUS(abus),
        .DBUS(dbus),
        .we  (we),
        .irq (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        abus   = a;
        tbData = d;
        tbDrv  = 1'b1;
        we     = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        tbDrv = 1'b0;
    endtask

    task automatic chkRd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        abus  = a;
        we    = 1'b0;
        tbDrv = 1'b0;
        #1;
        check({tag, "_drv"}, {31'b0, dut.rdEn}, 32'd1);
        check(tag, dbus, exp);
    endtask

    task automatic chkIdle(input string tag, input logic [31:0] a, input logic weVal);
        abus   = a;
        tbData = 32'hA5A5_0000;
        tbDrv  = weVal;
        we     = weVal;
        #1;
        check(tag, {31'b0, dut.rdEn}, 32'd0);
        we    = 1'b0;
        tbDrv = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rst    = 1'b1;
        abus   = '0;
        we     = 1'b0;
        tbDrv  = 1'b0;
        tbData = '0;
        #12;
        rst = 1'b0;

        // 20 cycles at DIVIDER=4 -> 5 ticks
        cycles(20);
        chkRd("tcnt_20cyc", A_TCNT, 32'd5);
        chkRd("tctl_idle", A_TCTL, 32'h0);

        // Asynchronous reset mid-count
        cycles(2);
        rst  = 1'b1;
        abus = A_TCNT;
        we   = 1'b0;
        #1;
        check("rst_bus_z", {31'b0, dut.rdEn}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        rst = 1'b0;
        chkRd("rst_tcnt", A_TCNT, 32'd0);
        chkRd("rst_tctl", A_TCTL, 32'h0);

        // Limit 3: hit on the third tick
        wr(A_TLIM, 32'd3);
        cycles(10);
        chkRd("lim_pre_tcnt", A_TCNT, 32'd2);
        chkRd("lim_pre_tctl", A_TCTL, 32'h0);
        cycles(1);
        chkRd("lim_hit_tcnt", A_TCNT, 32'd0);
        chkRd("lim_hit_tctl", A_TCTL, 32'h1);
        check("irq_ie_off", {31'b0, irq}, 32'd0);
        cycles(12);
        chkRd("overrun_tctl", A_TCTL, 32'h5);

        // Clear overrun only, then a clear racing a hit
        wr(A_TCTL, 32'h1);
        chkRd("clr_ovr_tctl", A_TCTL, 32'h1);
        cycles(10);
        wr(A_TCTL, 32'h0);
        chkRd("race_tctl", A_TCTL, 32'h5);
        chkRd("race_tcnt", A_TCNT, 32'd0);
        wr(A_TCTL, 32'h0);
        chkRd("clear_tctl", A_TCTL, 32'h0);

        // Free-running wrap with TLIM=0
        wr(A_TLIM, 32'd0);
        wr(A_TCNT, 32'hFFFF_FFFF);
        cycles(3);
        chkRd("wrap_pre", A_TCNT, 32'hFFFF_FFFF);
        cycles(1);
        chkRd("wrap_tcnt", A_TCNT, 32'd0);
        chkRd("wrap_tctl", A_TCTL, 32'h0);

        // Counter load in a tick cycle restarts the prescaler
        cycles(3);
        wr(A_TCNT, 32'd7);
        chkRd("load_tcnt", A_TCNT, 32'd7);
        cycles(3);
        chkRd("load_hold", A_TCNT, 32'd7);
        cycles(1);
        chkRd("load_next", A_TCNT, 32'd8);

        // Bus hygiene
        wr(A_TLIM, 32'h0000_1234);
        chkRd("tlim_read", A_TLIM, 32'h0000_1234);
        chkIdle("we_tcnt_z", A_TCNT, 1'b1);
        chkIdle("led_addr_z", 32'hF000_0014, 1'b0);
        chkIdle("near_tctl_z", 32'hF000_0124, 1'b0);

        // Interrupt path
        rst = 1'b1;
        #1;
        rst = 1'b0;
        wr(A_TCTL, 32'h10);
        wr(A_TLIM, 32'd2);
        cycles(5);
        check("irq_pre", {31'b0, irq}, 32'd0);
        chkRd("irq_pre_tctl", A_TCTL, IE_BIT);
        cycles(1);
        check("irq_set", {31'b0, irq}, {31'b0, IRQ_ON});
        chkRd("irq_set_tctl", A_TCTL, IE_BIT | 32'h1);
        wr(A_TCTL, 32'h10);
        check("irq_clr", {31'b0, irq}, 32'd0);
        chkRd("irq_clr_tctl", A_TCTL, IE_BIT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
